mdu: RTL and testbench

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. It takes the forwarded E-stage rs/rt operand values, which are already resolved by the E-stage forwarding muxes. It executes mult/multu/div/divu over a fixed multi-cycle latency and mthi/mtlo in a single cycle. It holds the architectural HI/LO registers and reports busy/stall to the hazard unit so that dependent mult/div/mfhi/mflo instructions wait in D.

---
 rtl/mdu.sv | 125 ++++++++++++
 tb/tb_mdu.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// MIPS E-stage multiply/divide unit: fixed-latency mult/div, one-cycle mthi/mtlo, owns HI/LO.
// Latency MULT_CYCLES/DIV_CYCLES; start while busy is dropped; md_stall holds D-stage MDU ops.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;
  logic          wr_q, wr_d;

  logic [63:0]        ext_a, ext_b, prod;
  logic signed [32:0] s_dvd, s_dvs, s_quo, s_rem;
  logic [31:0]        u_dvs, u_quo, u_rem;

  // Operand extension makes a single 64-bit multiply serve both signednesses.
  always_comb begin
    ext_a = (op == 3'd1) ? {{32{A[31]}}, A} : {32'b0, A};
    ext_b = (op == 3'd1) ? {{32{B[31]}}, B} : {32'b0, B};
    prod  = ext_a * ext_b;
  end

  // 33-bit signed divide absorbs the 0x80000000 / -1 overflow; zero divisor is masked.
  always_comb begin
    s_dvd = {A[31], A};
    s_dvs = (B == 32'd0) ? 33'sd1 : {B[31], B};
    s_quo = s_dvd / s_dvs;
    s_rem = s_dvd % s_dvs;
    u_dvs = (B == 32'd0) ? 32'd1 : B;
    u_quo = A / u_dvs;
    u_rem = A % u_dvs;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'd1, 3'd2: begin
              phi_d   = prod[63:32];
              plo_d   = prod[31:0];
              wr_d    = 1'b1;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = BUSY;
            end
            3'd3, 3'd4: begin
              phi_d   = (op == 3'd3) ? s_rem[31:0] : u_rem;
              plo_d   = (op == 3'd3) ? s_quo[31:0] : u_quo;
              wr_d    = (B != 32'd0);
              cnt_d   = CW'(DIV_CYCLES);
              state_d = BUSY;
            end
            3'd5:    hi_d = A;
            3'd6:    lo_d = A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt_q == CW'(1)) begin
          if (wr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      wr_q    <= wr_d;
    end
  end

  assign busy     = (state_q == BUSY);
  assign md_stall = (start && (op >= 3'd1) && (op <= 3'd4)) || busy;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed vector table, hand-written corner sequences, randomized ops vs a reference model.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_hi, m_lo;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
    .busy(busy), .md_stall(md_stall), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: architectural effect of one op, from the ISA rules in plain arithmetic.
  task automatic ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        inout logic [31:0] rh, inout logic [31:0] rl, output int cyc);
    longint sp, sx, sy, q, r;
    longint unsigned up;
    cyc = 0;
    case (o)
      3'd1: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sp = sx * sy;
        rh = sp[63:32];
        rl = sp[31:0];
        cyc = 5;
      end
      3'd2: begin
        up = {32'b0, x} * {32'b0, y};
        rh = up[63:32];
        rl = up[31:0];
        cyc = 5;
      end
      3'd3: begin
        if (y != 0) begin
          sx = longint'($signed(x));
          sy = longint'($signed(y));
          q = sx / sy;
          r = sx % sy;
          rl = q[31:0];
          rh = r[31:0];
        end
        cyc = 10;
      end
      3'd4: begin
        if (y != 0) begin
          rl = x / y;
          rh = x % y;
        end
        cyc = 10;
      end
      3'd5: rh = x;
      3'd6: rl = x;
      default: ;
    endcase
  endtask

  // Issue one op from an idle cycle, count busy cycles, then check HI/LO.
  task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                       input int ecyc);
    int cyc;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    #1;
    chk({name, " md_stall@start"}, md_stall, (o >= 3'd1 && o <= 3'd4));
    tick();
    start = 1'b0;
    op    = 3'd0;
    cyc   = 0;
    while (busy && cyc < 100) begin
      cyc++;
      tick();
    end
    chk({name, " busy cycles"}, cyc, ecyc);
    chk({name, " HI"}, hi, eh);
    chk({name, " LO"}, lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  vec_t vt[$];

  initial begin
    int  c;
    bit  stall_ok;
    logic [2:0]  ro;
    logic [31:0] ra, rb, eh, el;

    vt.push_back('{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5});
    vt.push_back('{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5});
    vt.push_back('{3'd5, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFE, 0});
    vt.push_back('{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    vt.push_back('{3'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10});
    vt.push_back('{3'd7, 32'hDEADBEEF, 32'd1,        32'h00000001, 32'h7FFFFFFC, 0});
    vt.push_back('{3'd5, 32'hAAAA0000, 32'd0,        32'hAAAA0000, 32'h7FFFFFFC, 0});
    vt.push_back('{3'd6, 32'h00005555, 32'd0,        32'hAAAA0000, 32'h00005555, 0});
    vt.push_back('{3'd4, 32'h00001234, 32'd0,        32'hAAAA0000, 32'h00005555, 10});
    vt.push_back('{3'd3, 32'h00001234, 32'd0,        32'hAAAA0000, 32'h00005555, 10});
    vt.push_back('{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10});
    vt.push_back('{3'd0, 32'h11111111, 32'd3,        32'h00000000, 32'h80000000, 0});

    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    chk("reset busy", busy, 1'b0);
    chk("reset md_stall", md_stall, 1'b0);
    chk("reset HI", hi, 32'd0);
    chk("reset LO", lo, 32'd0);
    reset = 1'b0;
    tick();

    foreach (vt[i]) do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
                          vt[i].hi, vt[i].lo, vt[i].cyc);

    // mtlo pulsed mid-multiply must be dropped.
    start = 1'b1; op = 3'd1; a = 32'd7; b = 32'd6;
    tick();
    start = 1'b0; op = 3'd0;
    stall_ok = md_stall;
    tick();
    start = 1'b1; op = 3'd6; a = 32'h99;
    #1;
    stall_ok &= md_stall;
    tick();
    start = 1'b0; op = 3'd0;
    c = 0;
    while (busy && c < 100) begin
      stall_ok &= md_stall;
      c++;
      tick();
    end
    chk("mtlo-in-busy stall held", stall_ok, 1'b1);
    chk("mtlo-in-busy remaining cycles", c, 3);
    chk("mtlo-in-busy HI", hi, 32'd0);
    chk("mtlo-in-busy LO", lo, 32'd42);

    // Reset at busy cycle 4 of a divide, with a simultaneous start that must be ignored.
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0; op = 3'd0;
    tick(); tick(); tick();
    chk("pre-reset busy", busy, 1'b1);
    reset = 1'b1; start = 1'b1; op = 3'd5; a = 32'h55;
    tick();
    chk("mid-reset busy", busy, 1'b0);
    chk("mid-reset HI", hi, 32'd0);
    chk("mid-reset LO", lo, 32'd0);
    reset = 1'b0; start = 1'b0; op = 3'd0;
    do_op("post-reset mult", 3'd1, 32'd3, 32'd3, 32'd0, 32'd9, 5);
    repeat (10) tick();
    chk("no stale div commit HI", hi, 32'd0);
    chk("no stale div commit LO", lo, 32'd9);

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 9));
        3: ra = -32'($urandom_range(1, 100));
        default: ;
      endcase
      eh = m_hi;
      el = m_lo;
      ref_op(ro, ra, rb, eh, el, c);
      do_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, eh, el, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
